// File: rtl/logic_cluster_pkg.sv
// Shared types and configuration-frame field layout for the logic cluster.
package logic_cluster_pkg;

    typedef enum logic [1:0] {
        UNCONFIG = 2'd0,
        LOADING  = 2'd1,
        ACTIVE   = 2'd2
    } cfg_state_t;

    // Per-LE field offsets, LSB first: lut, reg_mode, reset_val, fb_sel.
    localparam int LUT_LSB = 0;

    function automatic int le_cfg_width(input int k);
        return (1 << k) + k + 2;
    endfunction

    function automatic int reg_mode_ofs(input int k);
        return 1 << k;
    endfunction

    function automatic int reset_val_ofs(input int k);
        return (1 << k) + 1;
    endfunction

    function automatic int fb_lsb(input int k);
        return (1 << k) + 2;
    endfunction

endpackage

// File: rtl/logic_cluster_if.sv
// Routing-side and config-chain signals of one logic cluster tile.
interface logic_cluster_if #(
    parameter int NUM_LE = 4,
    parameter int LUT_K  = 4
);
    logic                     config_en;
    logic                     config_data_in;
    logic                     config_data_out;
    logic                     config_valid;
    logic                     config_err;
    logic                     le_en;
    logic                     le_nrst;
    logic [NUM_LE*LUT_K-1:0]  in_ext;
    logic [NUM_LE-1:0]        le_out;

    modport master (
        output config_en, config_data_in, le_en, le_nrst, in_ext,
        input  config_data_out, config_valid, config_err, le_out
    );

    modport slave (
        input  config_en, config_data_in, le_en, le_nrst, in_ext,
        output config_data_out, config_valid, config_err, le_out
    );
endinterface

// File: rtl/logic_cluster_le.sv
// One K-input logic element: input select with register feedback, LUT,
// optional output register.
module logic_element_k
    import logic_cluster_pkg::*;
#(
    parameter int NUM_LE = 4,
    parameter int LUT_K  = 4
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           active,
    input  logic                           activate,
    input  logic                           le_en,
    input  logic                           le_nrst,
    input  logic [le_cfg_width(LUT_K)-1:0] cfg,
    input  logic [LUT_K-1:0]               in_ext,
    input  logic [NUM_LE-1:0]              q_fb,
    output logic                           q,
    output logic                           le_out
);
    localparam int LUT_N         = 1 << LUT_K;
    localparam int REG_MODE_OFS  = reg_mode_ofs(LUT_K);
    localparam int RESET_VAL_OFS = reset_val_ofs(LUT_K);
    localparam int FB_LSB        = fb_lsb(LUT_K);

    logic [LUT_N-1:0] lut;
    logic             reg_mode;
    logic             reset_val;
    logic [LUT_K-1:0] fb_sel;
    logic [LUT_K-1:0] sel;
    logic             lut_out;

    assign lut       = cfg[LUT_LSB +: LUT_N];
    assign reg_mode  = cfg[REG_MODE_OFS];
    assign reset_val = cfg[RESET_VAL_OFS];
    assign fb_sel    = cfg[FB_LSB +: LUT_K];

    // Feedback taps only register outputs, so no combinational loop can form.
    always_comb begin
        sel = '0;
        for (int j = 0; j < LUT_K; j++) begin
            sel[j] = fb_sel[j] ? q_fb[j % NUM_LE] : in_ext[j];
        end
    end

    assign lut_out = lut[sel];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            q <= 1'b0;
        end else if (activate) begin
            q <= reset_val;
        end else if (!active) begin
            q <= 1'b0;
        end else if (!le_nrst) begin
            q <= reset_val;
        end else if (le_en) begin
            q <= lut_out;
        end
    end

    assign le_out = active & (reg_mode ? q : lut_out);

endmodule

// File: rtl/logic_cluster.sv
// Cluster of NUM_LE logic elements behind one serial config chain with a
// frame-length-checked loader.
module logic_cluster
    import logic_cluster_pkg::*;
#(
    parameter int NUM_LE = 4,
    parameter int LUT_K  = 4
) (
    input logic            clk,
    input logic            nrst,
    logic_cluster_if.slave bus
);
    localparam int LE_CFG     = le_cfg_width(LUT_K);
    localparam int FRAME_BITS = NUM_LE * LE_CFG;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    cfg_state_t            state;
    cfg_state_t            state_nxt;
    logic [FRAME_BITS-1:0] cram;
    logic [CNT_W-1:0]      cnt;
    logic                  config_err;
    logic                  activate;
    logic                  err_set;
    logic [NUM_LE-1:0]     q_all;

    always_comb begin
        state_nxt = state;
        activate  = 1'b0;
        err_set   = 1'b0;
        case (state)
            UNCONFIG, ACTIVE: begin
                if (bus.config_en) state_nxt = LOADING;
            end
            LOADING: begin
                if (!bus.config_en) begin
                    if (cnt == CNT_FULL) begin
                        state_nxt = ACTIVE;
                        activate  = 1'b1;
                    end else begin
                        state_nxt = UNCONFIG;
                        err_set   = 1'b1;
                    end
                end
            end
            default: state_nxt = UNCONFIG;
        endcase
    end

    // Count saturates one past a full frame so overlong loads stay detectable.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= UNCONFIG;
            cram       <= '0;
            cnt        <= '0;
            config_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.config_en) begin
                cram <= {cram[FRAME_BITS-2:0], bus.config_data_in};
                if (state != LOADING) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_SAT) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (bus.config_en && state != LOADING) begin
                config_err <= 1'b0;
            end else if (err_set) begin
                config_err <= 1'b1;
            end
        end
    end

    assign bus.config_data_out = cram[FRAME_BITS-1];
    assign bus.config_valid    = (state == ACTIVE);
    assign bus.config_err      = config_err;

    for (genvar i = 0; i < NUM_LE; i++) begin : g_le
        logic_element_k #(
            .NUM_LE (NUM_LE),
            .LUT_K  (LUT_K)
        ) u_le (
            .clk      (clk),
            .nrst     (nrst),
            .active   (state == ACTIVE),
            .activate (activate),
            .le_en    (bus.le_en),
            .le_nrst  (bus.le_nrst),
            .cfg      (cram[i*LE_CFG +: LE_CFG]),
            .in_ext   (bus.in_ext[i*LUT_K +: LUT_K]),
            .q_fb     (q_all),
            .q        (q_all[i]),
            .le_out   (bus.le_out[i])
        );
    end

endmodule

// File: tb/tb_logic_cluster.sv
// Bench for logic_cluster at default parameters: vector table, directed
// corner sequences and a randomized run against a frame-level model.
module tb_logic_cluster;
    localparam int NUM_LE = 4;
    localparam int LUT_K  = 4;
    localparam int LE_CFG = 22;
    localparam int FB     = 88;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic_cluster_if #(.NUM_LE(NUM_LE), .LUT_K(LUT_K)) bus ();

    logic_cluster #(.NUM_LE(NUM_LE), .LUT_K(LUT_K)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [15:0] in_ext;
        logic [3:0]  exp;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic [63:0] luts, input logic [3:0] rm,
                                               input logic [3:0] rv, input logic [15:0] fb);
        logic [FB-1:0] f;
        f = '0;
        for (int i = 0; i < NUM_LE; i++)
            f[i*LE_CFG +: LE_CFG] = {fb[i*4 +: 4], rv[i], rm[i], luts[i*16 +: 16]};
        return f;
    endfunction

    // Frame bits leave MSB first; config_en drops for one edge to close the load.
    task automatic send(input logic [127:0] f, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            bus.config_en      = 1'b1;
            bus.config_data_in = f[b];
            tick();
        end
        bus.config_en      = 1'b0;
        bus.config_data_in = 1'b0;
        tick();
    endtask

    function automatic logic model_lut(input logic [FB-1:0] f, input int i,
                                       input logic [15:0] inx, input logic [3:0] q);
        int base;
        int sel;
        int bitv;
        base = i * LE_CFG;
        sel  = 0;
        for (int j = 0; j < LUT_K; j++) begin
            bitv = f[base + 18 + j] ? int'(q[j % NUM_LE]) : int'(inx[i*4 + j]);
            sel += bitv << j;
        end
        return f[base + sel];
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FB-1:0] fa, fb_frame;
        logic [3:0]    q_m, lo, ex, rm_b, rv_b;
        logic [15:0]   x;

        for (int v = 0; v < 16; v++) begin
            x = {4'(v * 3), 4'(~v), 4'(v ^ 6), 4'(v)};
            vt[v].in_ext = x;
            vt[v].exp    = {^x[15:12], ^x[11:8], ^x[7:4], ^x[3:0]};
        end

        nrst = 1'b0;
        bus.config_en = 1'b0;
        bus.config_data_in = 1'b0;
        bus.le_en = 1'b0;
        bus.le_nrst = 1'b1;
        bus.in_ext = 16'hFFFF;
        tick();
        bus.in_ext = 16'h5A5A;
        #1;
        chk("reset le_out", 64'(bus.le_out), 64'h0);
        chk("reset config_valid", 64'(bus.config_valid), 64'h0);
        chk("reset config_err", 64'(bus.config_err), 64'h0);
        chk("reset config_data_out", 64'(bus.config_data_out), 64'h0);
        nrst = 1'b1;

        // combinational parity LUTs, zero latency
        fa = mk_frame({4{16'h6996}}, 4'h0, 4'h0, 16'h0);
        send(128'(fa), FB);
        chk("comb config_valid", 64'(bus.config_valid), 64'h1);
        for (int k = 0; k < 16; k++) begin
            bus.in_ext = vt[k].in_ext;
            #1;
            chk($sformatf("comb vec %0d", k), 64'(bus.le_out), 64'(vt[k].exp));
            #1;
        end

        // registered LE0 with reset_val=1
        bus.in_ext = '0;
        bus.le_en = 1'b0;
        fa = mk_frame({4{16'h6996}}, 4'b0001, 4'b0001, 16'h0);
        send(128'(fa), FB);
        chk("reg activation", 64'(bus.le_out[0]), 64'h1);
        bus.in_ext = 16'h0003;
        bus.le_en = 1'b1;
        tick();
        chk("reg sel3 le_en", 64'(bus.le_out[0]), 64'h0);
        bus.le_en = 1'b0;
        bus.in_ext = 16'h0001;
        tick();
        chk("reg hold", 64'(bus.le_out[0]), 64'h0);
        bus.le_nrst = 1'b0;
        tick();
        chk("reg le_nrst", 64'(bus.le_out[0]), 64'h1);
        bus.le_nrst = 1'b1;

        // frame length errors
        bus.in_ext = 16'h1111;
        send({$urandom, $urandom, $urandom, $urandom}, FB - 1);
        chk("short err", 64'(bus.config_err), 64'h1);
        chk("short valid", 64'(bus.config_valid), 64'h0);
        chk("short le_out", 64'(bus.le_out), 64'h0);
        send({$urandom, $urandom, $urandom, $urandom}, FB + 1);
        chk("long err", 64'(bus.config_err), 64'h1);
        chk("long valid", 64'(bus.config_valid), 64'h0);
        chk("long le_out", 64'(bus.le_out), 64'h0);
        send(128'(fa), FB);
        chk("recover err", 64'(bus.config_err), 64'h0);
        chk("recover valid", 64'(bus.config_valid), 64'h1);

        // register feedback toggler on LE0
        bus.in_ext = '0;
        bus.le_en = 1'b1;
        fa = mk_frame({{3{16'h6996}}, 16'h5555}, 4'b0001, 4'b0000, 16'h0001);
        send(128'(fa), FB);
        chk("fb start", 64'(bus.le_out[0]), 64'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("fb toggle %0d", k), 64'(bus.le_out[0]), 64'((k + 1) % 2));
        end

        // readback of frame A while frame B shifts in
        rm_b = 4'($urandom);
        rv_b = 4'($urandom);
        fb_frame = mk_frame({$urandom, $urandom}, rm_b, rv_b, 16'($urandom));
        for (int b = FB - 1; b >= 0; b--) begin
            bus.config_en      = 1'b1;
            bus.config_data_in = fb_frame[b];
            #1;
            chk($sformatf("readback bit %0d", b), 64'(bus.config_data_out), 64'(fa[b]));
            tick();
        end
        bus.config_en = 1'b0;
        tick();
        chk("frame B valid", 64'(bus.config_valid), 64'h1);

        // randomized run against the frame-level model
        q_m = rv_b;
        for (int c = 0; c < 300; c++) begin
            bus.in_ext  = 16'($urandom);
            bus.le_en   = 1'($urandom);
            bus.le_nrst = ($urandom_range(0, 7) != 0);
            #1;
            for (int i = 0; i < NUM_LE; i++) begin
                lo[i] = model_lut(fb_frame, i, bus.in_ext, q_m);
                ex[i] = rm_b[i] ? q_m[i] : lo[i];
            end
            chk($sformatf("random cycle %0d", c), 64'(bus.le_out), 64'(ex));
            if (!bus.le_nrst) q_m = rv_b;
            else if (bus.le_en) q_m = lo;
            tick();
        end

        // reconfig start mid-operation, then abandoned after one bit
        bus.le_nrst = 1'b1;
        bus.config_en = 1'b1;
        bus.config_data_in = 1'b0;
        tick();
        chk("midop valid", 64'(bus.config_valid), 64'h0);
        chk("midop le_out", 64'(bus.le_out), 64'h0);
        bus.config_en = 1'b0;
        tick();
        chk("midop abandon err", 64'(bus.config_err), 64'h1);

        // reset wins over a simultaneous shift
        bus.config_en = 1'b1;
        bus.config_data_in = 1'b1;
        nrst = 1'b0;
        tick();
        chk("rst+shift valid", 64'(bus.config_valid), 64'h0);
        chk("rst+shift data_out", 64'(bus.config_data_out), 64'h0);
        nrst = 1'b1;
        bus.config_en = 1'b0;
        tick();
        chk("rst+shift err", 64'(bus.config_err), 64'h0);
        chk("rst+shift stays unconfig", 64'(bus.config_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_cluster.md
Name: logic_cluster

Overview:
- Parametrised successor to the single 4-input logic element: NUM_LE logic elements with LUT_K-input LUTs, sharing one serial configuration chain and one clock.
- Adds a frame-length-checked config loader FSM, config readback, per-input local feedback from LE registers, and a synchronous logic clear.
- Sits between the routing fabric (cluster inputs and outputs) and the bitstream shift chain (config_data_in/out daisy-chained to the next tile).

Parameters:
- NUM_LE, 4, number of logic elements in the cluster
- LUT_K, 4, LUT inputs per LE; LUT holds 2^LUT_K bits
- Derived localparam LE_CFG = 2^LUT_K + LUT_K + 2 (22 at defaults)
- Derived localparam FRAME_BITS = NUM_LE*LE_CFG (88 at defaults)

Ports:
- clk  in  1  single clock for config and logic; all state updates on posedge
- nrst  in  1  synchronous active-low reset
- config_en  in  1  shift enable for the config chain
- config_data_in  in  1  serial config bit, MSB of frame first
- config_data_out  out  1  cram[FRAME_BITS-1], for readback and daisy-chaining
- config_valid  out  1  frame loaded and cluster active
- config_err  out  1  last load had wrong bit count
- le_en  in  1  register enable, shared by all LEs
- le_nrst  in  1  synchronous active-low logic clear (config untouched)
- in_ext  in  NUM_LE*LUT_K  routing inputs; LE i input j = in_ext[i*LUT_K+j]
- le_out  out  NUM_LE  LE outputs

Behaviour:
- Frame layout: LE i owns cram[i*LE_CFG +: LE_CFG]; field MSB to LSB: fb_sel[LUT_K-1:0], reset_val, reg_mode, lut[2^LUT_K-1:0].
- Shift: when config_en=1, cram <= {cram[FRAME_BITS-2:0], config_data_in}. After FRAME_BITS shifts, the first bit sent sits in cram[FRAME_BITS-1].
- FSM states: UNCONFIG, LOADING, ACTIVE. Reset enters UNCONFIG.
  - Reset also clears cram, bit count, config_err and all LE registers to 0.
- UNCONFIG or ACTIVE with config_en=1: go to LOADING; shift the bit; count=1; clear config_err.
- LOADING with config_en=1: shift; count increments, saturating at FRAME_BITS+1.
- LOADING with config_en=0:
  - count==FRAME_BITS: go to ACTIVE; every LE register <= its reset_val in this same edge.
  - otherwise: go to UNCONFIG; config_err <= 1 (sticky until the next load starts).
- config_valid = (state==ACTIVE), registered state.
- LE input select: input j = fb_sel[j] ? q[j % NUM_LE] : in_ext[i*LUT_K+j]. Feedback comes only from registers, so no combinational loops.
- lut_out = lut[sel].
- Register priority in ACTIVE: le_nrst=0 -> q<=reset_val; else le_en=1 -> q<=lut_out; else hold.
- Outside ACTIVE, q <= 0, except on the ACTIVE-entry edge.
- le_out[i] = ACTIVE ? (reg_mode ? q : lut_out) : 0.
  - Combinational mode: zero-cycle latency.
  - Registered mode: one cycle.
- Reconfig mid-operation: the first config_en cycle in ACTIVE moves to LOADING; le_out is 0 from the next cycle.
- Simultaneous nrst=0 with config_en: reset wins.
- config_data_out is valid in every state.

Decomposition:
- Package logic_cluster_pkg:
  - cfg_state_t enum {UNCONFIG, LOADING, ACTIVE}
  - le_cfg_width(k) function
  - field offset constants (LUT_LSB=0, REG_MODE_OFS=2^K, RESET_VAL_OFS=2^K+1, FB_LSB=2^K+2)
- Sub-module logic_element_k (LUT mux, input select, register, output mux), instantiated NUM_LE times.
- Loader FSM and cram live in the top.

Test Plan:
- Reset: nrst=0 one edge -> le_out=0, config_valid=0, config_err=0, config_data_out=0; in_ext toggling has no effect.
- Comb load: 88 bits, every LE lut=16'h6996, reg_mode=0, fb_sel=0 -> config_valid=1 one edge after config_en falls; in_ext[3:0] swept 0..15 -> le_out[0]=parity(sel) with zero latency.
- Registered: LE0 reg_mode=1, reset_val=1 -> le_out[0]=1 at activation.
  - sel=3, le_en=1 -> 0 after one edge.
  - le_en=0, sel=1 -> stays 0.
  - le_nrst=0 -> 1.
- Length error: shift 87 bits -> config_err=1, config_valid=0, le_out=0.
  - Shift 89 bits -> same result.
  - A following correct 88-bit load clears config_err.
- Feedback: LE0 lut=16'h5555 (NOT input0), reg_mode=1, fb_sel=4'b0001, reset_val=0, le_en=1 -> le_out[0] toggles every edge: 1,0,1,0.
- Readback: load frame A, then shift 88 bits of frame B -> config_data_out emits A MSB-first, bit-exact; afterwards ACTIVE with B's behaviour.
